// File: rtl/capture_pkg.sv
// Shared widths and state encoding for the ADC capture path.
package capture_pkg;

    localparam int unsigned WORD_WIDTH   = 128;
    localparam int unsigned SAMPLE_WIDTH = 16;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        FILL   = 4'b0010,
        STREAM = 4'b0100,
        DRAIN  = 4'b1000
    } state_e;

endpackage

// File: rtl/adc_sample_packer_if.sv
// Sample/handshake bundle between the ADC front end, the packer and the DDR write master.
interface adc_sample_packer_if #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH   = 512
);
    import capture_pkg::*;

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                    capture_start;
    logic [SAMPLE_WIDTH-1:0] adc_data;
    logic                    adc_valid;
    logic [WORD_WIDTH-1:0]   data_trans;
    logic                    data_trans_signal;
    logic                    data_ready_trans;
    logic                    capture_busy;
    logic [LVL_W-1:0]        fifo_level;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output capture_start, adc_data, adc_valid, data_ready_trans,
        input  data_trans, data_trans_signal, capture_busy, fifo_level, overflow, underflow
    );

    modport slave (
        input  capture_start, adc_data, adc_valid, data_ready_trans,
        output data_trans, data_trans_signal, capture_busy, fifo_level, overflow, underflow
    );

endinterface

// File: rtl/sync_fwft_fifo.sv
// First-word-fall-through FIFO: asynchronous head read, one-cycle write, level with one extra bit.
module sync_fwft_fifo #(
    parameter int unsigned WIDTH = capture_pkg::WORD_WIDTH,
    parameter int unsigned DEPTH = 512
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_c_o,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic                         full_c_o,
    output logic                         empty_c_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             wr_ok;
    logic             rd_ok;

    assign full_c_o    = (level_q == LVL_W'(DEPTH));
    assign empty_c_o   = (level_q == '0);
    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign wr_ok       = wr_en_i && (!full_c_o || rd_en_i);
    assign rd_ok       = rd_en_i && !empty_c_o;
    assign rd_data_c_o = mem_q[rd_ptr_q];
    assign level_o     = level_q;

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_q + LVL_W'(wr_ok) - LVL_W'(rd_ok);
        end
    end

endmodule

// File: rtl/adc_sample_packer.sv
// Packs ADC samples into 128-bit words, buffers them, and paces one frame out to the DDR write master.
module adc_sample_packer #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH   = 512,
    parameter int unsigned START_LEVEL  = 256,
    parameter int unsigned FRAME_WORDS  = 256000
) (
    input  logic               M_AXI_ACLK,
    input  logic               M_AXI_ARESETN,
    adc_sample_packer_if.slave bus
);
    import capture_pkg::*;

    localparam int unsigned LANES  = WORD_WIDTH / SAMPLE_WIDTH;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W  = 32;

    state_e                             state_q;
    logic [LANE_W-1:0]                  lane_q;
    logic [LANES-1:0][SAMPLE_WIDTH-1:0] word_q;
    logic                               push_q;
    logic [CNT_W-1:0]                   push_cnt_q;
    logic [CNT_W-1:0]                   pop_cnt_q;
    logic                               trans_sig_q;
    logic                               overflow_q;
    logic                               underflow_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             packing;
    logic             accept;
    logic             pop;
    logic             frame_pushed;
    logic             frame_popped;
    logic             last_lane;

    assign packing      = (state_q == FILL) || (state_q == STREAM);
    assign frame_pushed = (push_cnt_q >= CNT_W'(FRAME_WORDS));
    assign frame_popped = (pop_cnt_q >= CNT_W'(FRAME_WORDS));
    assign accept       = bus.adc_valid && packing && !frame_pushed;
    assign pop          = bus.data_ready_trans && (state_q != IDLE);
    assign last_lane    = (lane_q == LANE_W'(LANES - 1));

    sync_fwft_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (M_AXI_ACLK),
        .rst_ni      (M_AXI_ARESETN),
        .wr_en_i     (push_q),
        .wr_data_i   (word_q),
        .rd_en_i     (pop),
        .rd_data_c_o (bus.data_trans),
        .level_o     (fifo_level),
        .full_c_o    (fifo_full),
        .empty_c_o   (fifo_empty)
    );

    // Lane data needs no reset; push_q alone decides when word_q is meaningful.
    always_ff @(posedge M_AXI_ACLK) begin
        if (accept) begin
            word_q[lane_q] <= bus.adc_data;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            push_q      <= 1'b0;
            push_cnt_q  <= '0;
            pop_cnt_q   <= '0;
            trans_sig_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            push_q <= accept && last_lane;
            if (accept) begin
                lane_q <= last_lane ? '0 : lane_q + LANE_W'(1);
            end
            if (push_q) begin
                push_cnt_q <= push_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                pop_cnt_q <= pop_cnt_q + CNT_W'(1);
            end
            if (push_q && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (pop && fifo_empty) begin
                underflow_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.capture_start) begin
                        lane_q      <= '0;
                        push_cnt_q  <= '0;
                        pop_cnt_q   <= '0;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    if (fifo_level >= LVL_W'(START_LEVEL)) begin
                        state_q     <= STREAM;
                        trans_sig_q <= 1'b1;
                    end
                end
                STREAM: begin
                    // Any partially packed word is abandoned here.
                    if (frame_pushed) begin
                        state_q <= DRAIN;
                        lane_q  <= '0;
                    end
                end
                DRAIN: begin
                    if (frame_popped) begin
                        state_q     <= IDLE;
                        trans_sig_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_trans_signal = trans_sig_q;
    assign bus.capture_busy      = (state_q != IDLE);
    assign bus.fifo_level        = fifo_level;
    assign bus.overflow          = overflow_q;
    assign bus.underflow         = underflow_q;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed scoreboard bench: three packer instances cover the nominal frame, overflow and full-FIFO cases.
module tb_adc_sample_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        a_start, b_start, c_start;
    logic        a_ready, b_ready, c_ready;

    int checks   = 0;
    int failures = 0;

    logic [127:0]     q[$];
    logic [7:0][15:0] wacc;

    adc_sample_packer_if #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(8)) a_if ();
    adc_sample_packer_if #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(2)) b_if ();
    adc_sample_packer_if #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(8)) c_if ();

    assign a_if.capture_start    = a_start;
    assign a_if.adc_data         = adc_data;
    assign a_if.adc_valid        = adc_valid;
    assign a_if.data_ready_trans = a_ready;
    assign b_if.capture_start    = b_start;
    assign b_if.adc_data         = adc_data;
    assign b_if.adc_valid        = adc_valid;
    assign b_if.data_ready_trans = b_ready;
    assign c_if.capture_start    = c_start;
    assign c_if.adc_data         = adc_data;
    assign c_if.adc_valid        = adc_valid;
    assign c_if.data_ready_trans = c_ready;

    adc_sample_packer #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(8), .START_LEVEL(2), .FRAME_WORDS(4)) u_a (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .bus(a_if));
    adc_sample_packer #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(2), .START_LEVEL(2), .FRAME_WORDS(4)) u_b (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .bus(b_if));
    adc_sample_packer #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(8), .START_LEVEL(8), .FRAME_WORDS(16)) u_c (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .bus(c_if));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compares the head word against the oldest expected word in the scoreboard.
    task automatic pop_chk(input string tag, input logic [127:0] got);
        logic [127:0] exp;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%0h expected=none_queued", tag, got);
        end else begin
            exp = q.pop_front();
            assert (got === exp) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
            end
        end
    endtask

    task automatic feed(input int cyc, input logic [15:0] base, input bit record);
        adc_valid     = 1'b1;
        adc_data      = 16'(int'(base) + cyc);
        wacc[cyc % 8] = adc_data;
        if (record && (cyc % 8 == 7)) begin
            q.push_back(wacc);
        end
    endtask

    // Full frame on instance A, which must start from an empty FIFO.
    task automatic run_frame(input logic [15:0] base);
        int           pops;
        logic [127:0] w0;
        pops = 0;
        for (int j = 0; j < 8; j++) begin
            w0[16*j +: 16] = 16'(int'(base) + j);
        end
        q.delete();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("frame_busy_on_start", 128'(a_if.capture_busy), 128'(1));
        for (int cyc = 0; cyc < 48; cyc++) begin
            if (cyc < 40) begin
                feed(cyc, base, cyc < 32);
            end else begin
                adc_valid = 1'b0;
            end
            a_ready = 1'b0;
            if (a_if.data_trans_signal && (a_if.fifo_level != 0) && (pops < 4)) begin
                a_ready = 1'b1;
                pops++;
                pop_chk("frame_pop_word", a_if.data_trans);
            end
            tick();
            case (cyc)
                8: begin
                    chk("frame_level_first_word", 128'(a_if.fifo_level), 128'(1));
                    chk("frame_first_word_packing", a_if.data_trans, w0);
                end
                16: begin
                    chk("frame_level_two", 128'(a_if.fifo_level), 128'(2));
                    chk("frame_signal_not_yet", 128'(a_if.data_trans_signal), 128'(0));
                end
                17: chk("frame_signal_rise", 128'(a_if.data_trans_signal), 128'(1));
                33: chk("frame_busy_in_drain", 128'(a_if.capture_busy), 128'(1));
                34: begin
                    chk("frame_busy_cleared", 128'(a_if.capture_busy), 128'(0));
                    chk("frame_signal_fall", 128'(a_if.data_trans_signal), 128'(0));
                end
                default: ;
            endcase
        end
        a_ready   = 1'b0;
        adc_valid = 1'b0;
        chk("frame_pop_count", 128'(pops), 128'(4));
        chk("frame_queue_empty", 128'(q.size()), 128'(0));
        chk("frame_level_end", 128'(a_if.fifo_level), 128'(0));
        chk("frame_overflow_clear", 128'(a_if.overflow), 128'(0));
        chk("frame_underflow_clear", 128'(a_if.underflow), 128'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        adc_data  = '0;
        adc_valid = 1'b0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        wacc = '0;
        tick();
        tick();
        chk("reset_busy", 128'(a_if.capture_busy), 128'(0));
        chk("reset_signal", 128'(a_if.data_trans_signal), 128'(0));
        chk("reset_level", 128'(a_if.fifo_level), 128'(0));
        chk("reset_overflow", 128'(a_if.overflow), 128'(0));
        chk("reset_underflow", 128'(a_if.underflow), 128'(0));
        rst_n = 1'b1;
        tick();

        run_frame(16'h0000);

        // Underflow: two words stored, three back-to-back pops.
        q.delete();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (cyc < 16) begin
                feed(cyc, 16'h0200, 1'b1);
            end else begin
                adc_valid = 1'b0;
            end
            tick();
        end
        chk("unf_signal_rise", 128'(a_if.data_trans_signal), 128'(1));
        a_ready = 1'b1;
        pop_chk("unf_pop_word0", a_if.data_trans);
        tick();
        pop_chk("unf_pop_word1", a_if.data_trans);
        tick();
        chk("unf_not_yet", 128'(a_if.underflow), 128'(0));
        chk("unf_level_empty", 128'(a_if.fifo_level), 128'(0));
        tick();
        a_ready = 1'b0;
        chk("unf_flag_set", 128'(a_if.underflow), 128'(1));
        chk("unf_level_stays", 128'(a_if.fifo_level), 128'(0));

        // capture_start mid-STREAM must not restart or clear flags.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("start_ignored_flag", 128'(a_if.underflow), 128'(1));
        chk("start_ignored_busy", 128'(a_if.capture_busy), 128'(1));
        chk("start_ignored_signal", 128'(a_if.data_trans_signal), 128'(1));

        rst_n = 1'b0;
        tick();
        chk("midreset_busy", 128'(a_if.capture_busy), 128'(0));
        chk("midreset_signal", 128'(a_if.data_trans_signal), 128'(0));
        chk("midreset_level", 128'(a_if.fifo_level), 128'(0));
        chk("midreset_overflow", 128'(a_if.overflow), 128'(0));
        chk("midreset_underflow", 128'(a_if.underflow), 128'(0));
        rst_n = 1'b1;
        tick();

        run_frame(16'h0300);

        // Overflow on the depth-2 instance with no pops.
        q.delete();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            feed(cyc, 16'h0400, cyc < 32);
            tick();
            if (cyc == 16) begin
                chk("ovf_level_full", 128'(b_if.fifo_level), 128'(2));
                chk("ovf_not_yet", 128'(b_if.overflow), 128'(0));
            end
        end
        adc_valid = 1'b0;
        tick();
        chk("ovf_flag_set", 128'(b_if.overflow), 128'(1));
        chk("ovf_level_end", 128'(b_if.fifo_level), 128'(2));
        chk("ovf_busy_drain", 128'(b_if.capture_busy), 128'(1));
        pop_chk("ovf_head_is_word0", b_if.data_trans);

        // Simultaneous push and pop on a full depth-8 FIFO.
        q.delete();
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int cyc = 0; cyc < 72; cyc++) begin
            feed(cyc, 16'h0500, 1'b1);
            tick();
        end
        adc_valid = 1'b0;
        chk("full_level_before", 128'(c_if.fifo_level), 128'(8));
        chk("full_signal_high", 128'(c_if.data_trans_signal), 128'(1));
        c_ready = 1'b1;
        pop_chk("full_simul_pop", c_if.data_trans);
        tick();
        c_ready = 1'b0;
        chk("full_level_held", 128'(c_if.fifo_level), 128'(8));
        chk("full_no_overflow", 128'(c_if.overflow), 128'(0));
        for (int i = 0; i < 8; i++) begin
            c_ready = 1'b1;
            pop_chk("full_order", c_if.data_trans);
            tick();
        end
        c_ready = 1'b0;
        chk("full_level_drained", 128'(c_if.fifo_level), 128'(0));
        chk("full_underflow_clear", 128'(c_if.underflow), 128'(0));
        chk("full_overflow_clear", 128'(c_if.overflow), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_sample_packer.md
# adc_sample_packer

Upstream stage of the AXI-Full DDR write master. Packs 16-bit ADC samples into 128-bit words and buffers them in a first-word-fall-through FIFO. Raises `data_trans_signal` once enough words are buffered; the master starts on that edge. Pops one word for every `data_ready_trans` the master issues, for exactly one frame per `capture_start`.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 16: ADC sample width. `128/SAMPLE_WIDTH` must be an integer, giving `LANES` = 8.
- `FIFO_DEPTH`, 512: FIFO depth in 128-bit words; must be a power of two.
- `START_LEVEL`, 256: FIFO level at which `data_trans_signal` rises. One master burst; must be ≤ `FIFO_DEPTH`.
- `FRAME_WORDS`, 256000: words per frame. Equals the master's `BURST_TIMES` × `C_M_AXI_BURST_LEN`.

Ports:
- `M_AXI_ACLK` in 1: the single clock.
- `M_AXI_ARESETN` in 1: synchronous, active-low reset.
- `capture_start` in 1: one-cycle pulse that arms a frame. Honoured only in IDLE.
- `adc_data` in `SAMPLE_WIDTH`: ADC sample.
- `adc_valid` in 1: qualifies `adc_data`.
- `data_trans` out 128: FIFO head word, read combinationally.
- `data_trans_signal` out 1: level output; its rising edge starts the master.
- `data_ready_trans` in 1: pop strobe from the master. The master consumes `data_trans` on this same clock edge.
- `capture_busy` out 1: high in every state except IDLE.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: current number of stored words.
- `overflow` out 1: sticky; a word was dropped.
- `underflow` out 1: sticky; a pop occurred while the FIFO was empty.

## Operation
State machine with states IDLE, FILL, STREAM, DRAIN:
- **IDLE**: `capture_start` clears the lane counter, push/pop counters, `overflow` and `underflow`, then moves to FILL. `adc_valid` is ignored.
- **FILL**: packs samples and pushes words. When `fifo_level` ≥ `START_LEVEL`, moves to STREAM and sets `data_trans_signal`.
- **STREAM**: keeps packing and pushing. After the push count reaches `FRAME_WORDS`, moves to DRAIN and ignores further samples.
- **DRAIN**: no pushes. When the pop count reaches `FRAME_WORDS`, moves to IDLE and clears `data_trans_signal`.
- Pops are counted in FILL, STREAM and DRAIN. A pop outside IDLE when the frame is complete is still counted as underflow if the FIFO is empty.

Packing:
- The lane counter runs 0..`LANES`-1.
- Sample k lands in bits [16k+15:16k], so the first sample goes to the lowest lane.
- On the sample that fills lane 7, the completed word is pushed the next cycle and the counter wraps to 0.
- A partial word left when the push count reaches `FRAME_WORDS` is discarded.

FIFO rules:
- Push while full: the word is dropped, `overflow` is set, and it still counts toward `FRAME_WORDS`.
- Pop while empty: pointers are unchanged, `underflow` is set, the pop counts, and `data_trans` shows `mem[rd_ptr]` (stale data).
- Simultaneous push and pop while full: both succeed and the level is unchanged.
- Simultaneous push and pop while empty: the pop is an underflow and the push is stored.
- Pointers wrap modulo `FIFO_DEPTH`; the level is kept with one extra bit.
- Push and pop counters are 32 bits.

Reset values: `data_trans` = `mem[0]` (contents undefined); all other outputs 0; state IDLE. Reset mid-frame abandons the frame and empties the FIFO.

## Timing
- `capture_start` → `capture_busy` high: 1 cycle.
- 8th `adc_valid` of a word → `fifo_level` +1: 2 cycles (pack register, then memory write).
- A pushed word is visible on `data_trans` in the same cycle `fifo_level` increments.
- `fifo_level` reaching `START_LEVEL` → `data_trans_signal` high: 1 cycle.
- Pop: on the edge where `data_ready_trans`=1, the head advances and the next word is visible on the following cycle. Zero-bubble pops every cycle are supported.
- `data_trans_signal` stays low for at least 2 cycles between frames, so the master's 2-flop edge detect always re-fires.

## Structure
- Shared package `capture_pkg`: `WORD_WIDTH`=128, `SAMPLE_WIDTH`, and the state enum with one-hot encoding `IDLE`=4'b0001, `FILL`=4'b0010, `STREAM`=4'b0100, `DRAIN`=4'b1000.
- Sub-module `sync_fwft_fifo`: register or distributed-RAM array with asynchronous read, plus level/full/empty logic and a 1-cycle write.
- Packer and state machine live in `adc_sample_packer`.

## Test plan
Bench parameters: `FIFO_DEPTH`=8, `START_LEVEL`=2, `FRAME_WORDS`=4, unless a line says otherwise.
- **Packing order**: start, then 16 consecutive samples 0x0000..0x000F. The first word is 0x0007_0006_0005_0004_0003_0002_0001_0000 and the second is 0x000F_..._0008. `data_trans_signal` rises 1 cycle after `fifo_level`=2.
- **Full frame**: 32 samples with `data_ready_trans` pulsing every cycle after the rise. Exactly 4 pops occur, then DRAIN→IDLE. `data_trans_signal` falls, no flags are set, and samples 33+ are ignored.
- **Overflow**: `FIFO_DEPTH`=2, `START_LEVEL`=2, 32 samples, no pops. Words 3 and 4 are dropped, `overflow`=1 and `fifo_level`=2.
- **Underflow**: after the rise, 3 consecutive pops with only 2 words stored. The 3rd pop sets `underflow`=1 and `fifo_level` stays 0.
- **Simultaneous push and pop while full**: level stays 8 and the word order is preserved.
- **Mid-frame reset and restart**: `M_AXI_ARESETN`=0 for 1 cycle mid-STREAM gives all outputs 0 and `fifo_level`=0. A new `capture_start` then completes a clean frame. A `capture_start` issued during STREAM is ignored.
